// File: rtl/xs3_pkg.sv
// Shared state encoding, BCD/excess-3 constants and the digit validity check
// for the excess-3 count source.
package xs3_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam logic [3:0] XS3_OFFSET = 4'd3;
  localparam logic [3:0] BCD_MAX    = 4'd9;

  function automatic logic is_bcd(input logic [3:0] digit);
    return (digit <= BCD_MAX);
  endfunction

endpackage

// File: rtl/xs3_digit.sv
// One decimal digit: combinational up/down step with ripple carry/borrow,
// plus the +3 excess-3 encoder for the value being registered.
module xs3_digit
  import xs3_pkg::*;
(
  input  logic [3:0] digit_i,
  input  logic       up_i,
  input  logic       cin_i,
  input  logic [3:0] enc_i,
  output logic [3:0] nxt_c_o,
  output logic       cout_c_o,
  output logic [3:0] xs3_c_o
);

  // cin_i means "this digit must move"; cout_c_o passes the wrap on.
  always_comb begin
    nxt_c_o  = digit_i;
    cout_c_o = 1'b0;
    if (cin_i) begin
      if (up_i) begin
        if (digit_i >= BCD_MAX) begin
          nxt_c_o  = 4'd0;
          cout_c_o = 1'b1;
        end else begin
          nxt_c_o = digit_i + 4'd1;
        end
      end else begin
        if (digit_i == 4'd0) begin
          nxt_c_o  = BCD_MAX;
          cout_c_o = 1'b1;
        end else begin
          nxt_c_o = digit_i - 4'd1;
        end
      end
    end
  end

  assign xs3_c_o = enc_i + XS3_OFFSET;

endmodule

// File: rtl/xs3_count_source.sv
// Multi-digit BCD counter presenting its count and excess-3 code through a
// valid/ready handshake; the count advances only on accepted transfers.
module xs3_count_source
  import xs3_pkg::*;
#(
  parameter int unsigned pDigits = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   en,
  input  logic                   up,
  input  logic                   load,
  input  logic [4*pDigits-1:0]   load_val,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [4*pDigits-1:0]   HiCount,
  output logic [4*pDigits-1:0]   Excess_3_out,
  output logic                   carry,
  output logic                   load_err
);

  localparam int unsigned W = 4 * pDigits;

  state_e         state_q, state_d;
  logic [W-1:0]   count_q, count_d;
  logic [W-1:0]   xs3_q, xs3_d;
  logic           valid_q, valid_d;
  logic           carry_q, carry_d;
  logic           load_err_q, load_err_d;

  logic [W-1:0]   step_val;
  logic [W-1:0]   xs3_enc;
  logic [pDigits:0] chain;
  logic           load_ok;

  // Digit 0 always moves on a step; the last cout marks a full wrap.
  assign chain[0] = 1'b1;

  for (genvar g = 0; g < int'(pDigits); g++) begin : g_digit
    xs3_digit u_digit (
      .digit_i  (count_q[4*g +: 4]),
      .up_i     (up),
      .cin_i    (chain[g]),
      .enc_i    (count_d[4*g +: 4]),
      .nxt_c_o  (step_val[4*g +: 4]),
      .cout_c_o (chain[g+1]),
      .xs3_c_o  (xs3_enc[4*g +: 4])
    );
  end

  always_comb begin
    load_ok = 1'b1;
    for (int i = 0; i < int'(pDigits); i++) begin
      if (!is_bcd(load_val[4*i +: 4])) load_ok = 1'b0;
    end
  end

  // Next-state, count and pulse logic; clr overrides load and handshake.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    carry_d    = 1'b0;
    load_err_d = 1'b0;
    if (clr) begin
      state_d = IDLE;
      count_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (load) begin
            if (load_ok) count_d    = load_val;
            else         load_err_d = 1'b1;
          end else if (en) begin
            state_d = RUN;
          end
        end
        RUN: begin
          if (out_ready) begin
            count_d = step_val;
            carry_d = chain[pDigits];
            if (!en) state_d = IDLE;
          end else if (!en) begin
            state_d = DRAIN;
          end
        end
        DRAIN: begin
          if (out_ready) begin
            count_d = step_val;
            carry_d = chain[pDigits];
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
          count_d = '0;
        end
      endcase
    end
    xs3_d   = xs3_enc;
    valid_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      count_q    <= '0;
      xs3_q      <= {pDigits{XS3_OFFSET}};
      valid_q    <= 1'b0;
      carry_q    <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      xs3_q      <= xs3_d;
      valid_q    <= valid_d;
      carry_q    <= carry_d;
      load_err_q <= load_err_d;
    end
  end

  assign out_valid    = valid_q;
  assign HiCount      = count_q;
  assign Excess_3_out = xs3_q;
  assign carry        = carry_q;
  assign load_err     = load_err_q;

endmodule

// File: tb/tb_xs3_count_source.sv
// Directed bench: one-digit and two-digit instances share stimulus; expected
// values are hand-computed BCD / excess-3 codes.
module tb_xs3_count_source;

  logic       clk;
  logic       rst_n, clr, en, up, load, out_ready;
  logic [7:0] lv;

  logic       v1, c1, le1;
  logic [3:0] hc1, x1;
  logic       v2, c2, le2;
  logic [7:0] hc2, x2;

  int n_vec;
  int n_err;

  xs3_count_source #(.pDigits(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .en(en), .up(up), .load(load),
    .load_val(lv[3:0]), .out_ready(out_ready), .out_valid(v1),
    .HiCount(hc1), .Excess_3_out(x1), .carry(c1), .load_err(le1)
  );

  xs3_count_source #(.pDigits(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .en(en), .up(up), .load(load),
    .load_val(lv), .out_ready(out_ready), .out_valid(v2),
    .HiCount(hc2), .Excess_3_out(x2), .carry(c2), .load_err(le2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0; clr = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0;
    out_ready = 1'b0; lv = 8'h00;
    tick(); tick();

    check_val("rst_hc2",  32'(hc2), 32'h00);
    check_val("rst_x2",   32'(x2),  32'h33);
    check_val("rst_x1",   32'(x1),  32'h3);
    check_val("rst_v2",   32'(v2),  32'h0);
    check_val("rst_c2",   32'(c2),  32'h0);
    check_val("rst_le2",  32'(le2), 32'h0);
    rst_n = 1'b1;
    tick();

    // one digit up-count through the full decade
    en = 1'b1; out_ready = 1'b1; up = 1'b1;
    tick();
    check_val("run_v1", 32'(v1), 32'h1);
    check_val("run_x1", 32'(x1), 32'h3);
    for (int i = 1; i <= 9; i++) begin
      tick();
      check_val("seq_x1", 32'(x1), 32'(i + 3));
      check_val("seq_c1", 32'(c1), 32'h0);
    end
    tick();
    check_val("wrap_x1",  32'(x1),  32'h3);
    check_val("wrap_c1",  32'(c1),  32'h1);
    check_val("wrap_hc2", 32'(hc2), 32'h10);
    check_val("wrap_c2",  32'(c2),  32'h0);
    en = 1'b0;
    tick();
    check_val("endrun_v1",  32'(v1),  32'h0);
    check_val("endrun_hc1", 32'(hc1), 32'h1);
    check_val("endrun_c1",  32'(c1),  32'h0);
    check_val("endrun_hc2", 32'(hc2), 32'h11);

    // load 99 then one up step wraps to 00
    load = 1'b1; lv = 8'h99;
    tick();
    check_val("ld99_hc2", 32'(hc2), 32'h99);
    check_val("ld99_x2",  32'(x2),  32'hCC);
    check_val("ld99_le2", 32'(le2), 32'h0);
    load = 1'b0; en = 1'b1;
    tick();
    check_val("ld99_run_v2",  32'(v2),  32'h1);
    check_val("ld99_run_hc2", 32'(hc2), 32'h99);
    en = 1'b0;
    tick();
    check_val("up99_hc2", 32'(hc2), 32'h00);
    check_val("up99_x2",  32'(x2),  32'h33);
    check_val("up99_c2",  32'(c2),  32'h1);
    check_val("up99_c1",  32'(c1),  32'h1);
    check_val("up99_v2",  32'(v2),  32'h0);

    // down from 00 wraps to 99
    up = 1'b0; en = 1'b1;
    tick();
    en = 1'b0;
    tick();
    check_val("dn00_hc2", 32'(hc2), 32'h99);
    check_val("dn00_x2",  32'(x2),  32'hCC);
    check_val("dn00_c2",  32'(c2),  32'h1);
    tick();
    check_val("dn00_c2_pulse", 32'(c2), 32'h0);

    // stall at 7 with up toggled while stalled
    load = 1'b1; lv = 8'h07;
    tick();
    load = 1'b0; out_ready = 1'b0; en = 1'b1; up = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      check_val("stall_v2",  32'(v2),  32'h1);
      check_val("stall_hc2", 32'(hc2), 32'h07);
    end
    up = 1'b1; out_ready = 1'b1;
    tick();
    check_val("stall_go_hc2", 32'(hc2), 32'h08);
    check_val("stall_go_x2",  32'(x2),  32'h3B);

    // drop en while stalled -> DRAIN, then clr discards the held value
    out_ready = 1'b0; en = 1'b0;
    tick();
    check_val("drain_v2",  32'(v2),  32'h1);
    check_val("drain_hc2", 32'(hc2), 32'h08);
    clr = 1'b1;
    tick();
    check_val("clr_v2",  32'(v2),  32'h0);
    check_val("clr_hc2", 32'(hc2), 32'h00);
    check_val("clr_x2",  32'(x2),  32'h33);
    clr = 1'b0;
    tick();
    check_val("clr_idle_v2", 32'(v2), 32'h0);

    // invalid load in IDLE, then a load in RUN is ignored
    load = 1'b1; lv = 8'h0A;
    tick();
    check_val("bad_le2", 32'(le2), 32'h1);
    check_val("bad_le1", 32'(le1), 32'h1);
    check_val("bad_hc2", 32'(hc2), 32'h00);
    load = 1'b0;
    tick();
    check_val("bad_le2_pulse", 32'(le2), 32'h0);
    en = 1'b1; out_ready = 1'b0;
    tick();
    load = 1'b1; lv = 8'h55;
    tick();
    check_val("runld_le2", 32'(le2), 32'h0);
    check_val("runld_hc2", 32'(hc2), 32'h00);
    check_val("runld_v2",  32'(v2),  32'h1);
    load = 1'b0; clr = 1'b1;
    tick();
    clr = 1'b0;

    // borrow across digits: 10 down to 09
    load = 1'b1; lv = 8'h10;
    tick();
    load = 1'b0; up = 1'b0; en = 1'b1; out_ready = 1'b1;
    tick();
    en = 1'b0;
    tick();
    check_val("borrow_hc2", 32'(hc2), 32'h09);
    check_val("borrow_x2",  32'(x2),  32'h3C);
    check_val("borrow_c2",  32'(c2),  32'h0);
    check_val("borrow_v2",  32'(v2),  32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
